mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_pkg.sv | 6 +
 rtl/mem_arb_priority.sv | 26 ++
 rtl/mem_port_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the unified-memory port arbiter
package mem_port_arbiter_pkg;
  localparam int WORD_SIZE_DEF = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_t;
endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: data-first winner selection with a saturating fetch starvation counter
module mem_arb_priority
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   arb,
  input  logic   i_req,
  input  logic   d_req,
  output owner_t win
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic          starved;
  always_comb begin
    starved = starve_cnt == SW'(STARVE_LIMIT);
    win = (d_req && !(i_req && starved)) ? OWNER_DATA : OWNER_FETCH;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset)
      starve_cnt <= '0;
    else if (arb)
      starve_cnt <= (win == OWNER_DATA && i_req) ? (starved ? starve_cnt : starve_cnt + SW'(1)) : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between fetch and data ports
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_t        state;
  owner_t        owner, win;
  logic [CW-1:0] cnt;
  logic          grant, last;
  always_comb begin
    grant = state == IDLE && (i_req || d_req);
    last  = state == ACCESS && cnt == CW'(LATENCY - 1);
  end
  mem_arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .Clk(Clk), .Reset(Reset), .arb(grant), .i_req(i_req), .d_req(d_req), .win(win)
  );
  // m_read/m_write double as the latched direction of the access in flight
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state   <= IDLE;
      owner   <= OWNER_FETCH;
      cnt     <= '0;
      busy    <= 1'b0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (grant) begin
        state   <= ACCESS;
        cnt     <= '0;
        busy    <= 1'b1;
        owner   <= win;
        m_addr  <= win == OWNER_DATA ? d_addr : i_addr;
        m_wdata <= win == OWNER_DATA ? d_wdata : '0;
        m_read  <= win == OWNER_FETCH || !d_we;
        m_write <= win == OWNER_DATA && d_we;
      end else if (state == ACCESS) begin
        cnt <= cnt + CW'(1);
        if (last) begin
          state   <= RESP;
          m_read  <= 1'b0;
          m_write <= 1'b0;
          i_ack   <= owner == OWNER_FETCH;
          d_ack   <= owner == OWNER_DATA;
          if (m_read && owner == OWNER_FETCH) i_rdata <= m_rdata;
          if (m_read && owner == OWNER_DATA) d_rdata <= m_rdata;
        end
      end else if (state == RESP) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
endmodule
